// File: rtl/cache_line_arbiter_pkg.sv
// rtl/cache_line_arbiter_pkg.sv - shared types and constants for the cache line arbiter
package cache_line_arbiter_pkg;

    localparam int ADDR_W   = 32;
    localparam int LINE_W   = 256;
    localparam int OFFSET_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        RELEASE
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } arb_owner_t;

endpackage

// File: rtl/cache_line_arbiter_if.sv
// rtl/cache_line_arbiter_if.sv - cache-side and physical-memory-side signal bundle
interface cache_line_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    // I-cache miss path
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic              i_resp;
    logic              i_error;
    logic [LINE_W-1:0] i_rdata;

    // D-cache miss / writeback path
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic              d_resp;
    logic              d_error;
    logic [LINE_W-1:0] d_rdata;

    // physical memory port
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic              pmem_resp;
    logic              pmem_error;
    logic [LINE_W-1:0] pmem_rdata;

    // arbiter view
    modport master (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata,
        input  pmem_resp, pmem_error, pmem_rdata,
        output i_resp, i_error, i_rdata, d_resp, d_error, d_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    // caches and memory view
    modport slave (
        output i_read, i_address, d_read, d_write, d_address, d_wdata,
        output pmem_resp, pmem_error, pmem_rdata,
        input  i_resp, i_error, i_rdata, d_resp, d_error, d_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );

endinterface

// File: rtl/sat_counter32.sv
// rtl/sat_counter32.sv - 32-bit enabled counter that sticks at all-ones
module sat_counter32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [31:0] count
);

    // count enabled cycles, holding at the maximum instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/cache_line_arbiter.sv
// rtl/cache_line_arbiter.sv - round-robin sharing of the line-wide memory port between I and D caches
module cache_line_arbiter
    import cache_line_arbiter_pkg::*;
#(
    parameter int ADDR_W   = cache_line_arbiter_pkg::ADDR_W,
    parameter int LINE_W   = cache_line_arbiter_pkg::LINE_W,
    parameter int OFFSET_W = cache_line_arbiter_pkg::OFFSET_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cache_line_arbiter_if.master  bus,
    output logic [31:0]           conflict_count
);

    arb_state_t        state;
    arb_owner_t        last_grant;
    logic              cmd_read;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_address;
    logic [LINE_W-1:0] cmd_wdata;

    logic i_req;
    logic d_req;
    logic grant_i;
    logic conflict;

    // line offset bits never reach memory
    logic unused_offset;
    assign unused_offset = ^{bus.i_address[OFFSET_W-1:0], bus.d_address[OFFSET_W-1:0]};

    assign i_req    = bus.i_read;
    assign d_req    = bus.d_read | bus.d_write;
    assign conflict = (state == IDLE) && i_req && d_req;
    // on a tie the side that did not win last time goes first
    assign grant_i  = i_req && (!d_req || (last_grant == OWN_D));

    // arbitration FSM and request latch; command outputs come straight from these registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= OWN_D;
            cmd_read    <= 1'b0;
            cmd_write   <= 1'b0;
            cmd_address <= '0;
            cmd_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        cmd_read    <= 1'b1;
                        cmd_write   <= 1'b0;
                        cmd_address <= {bus.i_address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                        cmd_wdata   <= '0;
                        state       <= BUSY_I;
                    end else if (d_req) begin
                        // a writeback takes priority over a read asserted alongside it
                        cmd_read    <= !bus.d_write;
                        cmd_write   <= bus.d_write;
                        cmd_address <= {bus.d_address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                        cmd_wdata   <= bus.d_write ? bus.d_wdata : '0;
                        state       <= BUSY_D;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (bus.pmem_resp) begin
                        cmd_read   <= 1'b0;
                        cmd_write  <= 1'b0;
                        last_grant <= (state == BUSY_I) ? OWN_I : OWN_D;
                        state      <= RELEASE;
                    end
                end
                RELEASE: begin
                    // gives the finished requester a cycle to drop its request
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.pmem_read    = cmd_read;
    assign bus.pmem_write   = cmd_write;
    assign bus.pmem_address = cmd_address;
    assign bus.pmem_wdata   = cmd_wdata;

    // completion is routed combinationally to whichever side owns the port
    assign bus.i_resp  = (state == BUSY_I) && bus.pmem_resp;
    assign bus.d_resp  = (state == BUSY_D) && bus.pmem_resp;
    assign bus.i_error = (state == BUSY_I) && bus.pmem_resp && bus.pmem_error;
    assign bus.d_error = (state == BUSY_D) && bus.pmem_resp && bus.pmem_error;
    assign bus.i_rdata = bus.pmem_rdata;
    assign bus.d_rdata = bus.pmem_rdata;

    sat_counter32 u_conflict_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (conflict),
        .count (conflict_count)
    );

endmodule

// File: tb/tb_cache_line_arbiter.sv
// tb/tb_cache_line_arbiter.sv - self-checking bench for cache_line_arbiter
module tb_cache_line_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] conflict_count;

    cache_line_arbiter_if bus ();

    cache_line_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .conflict_count (conflict_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // memory model controls
    logic         mem_rand = 1'b0;
    logic         spur     = 1'b0;
    int           mem_lat  = 0;
    logic         mem_err  = 1'b0;
    logic [255:0] mem_data = '0;

    // last cycle's responses, published by the monitor
    logic mon_i_resp = 1'b0;
    logic mon_d_resp = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [31:0] align(input logic [31:0] a);
        return {a[31:5], 5'b0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // physical memory: answers each command after a latency, reset with the design
    initial begin
        int           cnt;
        int           lat;
        bit           started;
        logic         err;
        logic [255:0] data;
        cnt = 0; lat = 0; started = 0; err = 1'b0; data = '0;
        bus.pmem_resp  = 1'b0;
        bus.pmem_error = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.pmem_resp  = 1'b0;
            bus.pmem_error = 1'b0;
            if (!rst_n) begin
                started = 0;
                cnt     = 0;
            end else if (bus.pmem_read || bus.pmem_write) begin
                if (!started) begin
                    started = 1;
                    cnt     = 0;
                    if (mem_rand) begin
                        lat  = $urandom_range(0, 3);
                        err  = ($urandom_range(0, 3) == 0);
                        data = rand256();
                    end else begin
                        lat  = mem_lat;
                        err  = mem_err;
                        data = mem_data;
                    end
                end
                if (cnt == lat) begin
                    bus.pmem_resp  = 1'b1;
                    bus.pmem_error = err;
                    bus.pmem_rdata = data;
                    started        = 0;
                end else begin
                    cnt++;
                    bus.pmem_rdata = rand256();
                end
            end else begin
                started = 0;
                if (spur) begin
                    bus.pmem_resp  = 1'b1;
                    bus.pmem_error = 1'b1;
                    bus.pmem_rdata = rand256();
                end
            end
        end
    end

    // transaction-level reference: round-robin on ties, one command per grant, one quiet cycle after each completion
    initial begin
        int           cool;
        bit           busy;
        bit           exp_cmd;
        bit           own_i;
        bit           last_i;
        bit           ireq;
        bit           dreq;
        bit           exp_i;
        bit           exp_d;
        logic [31:0]  mcnt;
        logic         e_rd;
        logic         e_wr;
        logic [31:0]  e_addr;
        logic [255:0] e_wdata;
        cool = 0; busy = 0; exp_cmd = 0; own_i = 0; last_i = 0; mcnt = '0;
        e_rd = 0; e_wr = 0; e_addr = '0; e_wdata = '0;
        forever begin
            @(negedge clk);
            mon_i_resp = bus.i_resp;
            mon_d_resp = bus.d_resp;
            if (!rst_n) begin
                busy = 0; exp_cmd = 0; cool = 0; last_i = 0; mcnt = '0;
                check("rst_ctrl", {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp, bus.i_error, bus.d_error}, '0);
                check("rst_addr", bus.pmem_address, '0);
                check("rst_wdata", bus.pmem_wdata, '0);
                check("rst_count", conflict_count, '0);
            end else begin
                if (exp_cmd) begin
                    busy    = 1;
                    exp_cmd = 0;
                end
                if (busy) begin
                    check("mon_cmd", {bus.pmem_read, bus.pmem_write}, {e_rd, e_wr});
                    check("mon_addr", bus.pmem_address, e_addr);
                    check("mon_wdata", bus.pmem_wdata, e_wdata);
                end else begin
                    check("mon_cmd_off", {bus.pmem_read, bus.pmem_write}, 2'b00);
                end
                exp_i = busy && own_i && bus.pmem_resp;
                exp_d = busy && !own_i && bus.pmem_resp;
                check("mon_resp", {bus.i_resp, bus.d_resp, bus.i_error, bus.d_error},
                      {exp_i, exp_d, exp_i && bus.pmem_error, exp_d && bus.pmem_error});
                if (exp_i) check("mon_i_rdata", bus.i_rdata, bus.pmem_rdata);
                if (exp_d) check("mon_d_rdata", bus.d_rdata, bus.pmem_rdata);
                check("mon_conflict_count", conflict_count, mcnt);
                if (busy) begin
                    if (bus.pmem_resp) begin
                        busy   = 0;
                        last_i = own_i;
                        cool   = 1;
                    end
                end else if (cool > 0) begin
                    cool--;
                end else begin
                    ireq = bus.i_read;
                    dreq = bus.d_read || bus.d_write;
                    if (ireq || dreq) begin
                        if (ireq && dreq) begin
                            own_i = !last_i;
                            if (mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 1;
                        end else begin
                            own_i = ireq;
                        end
                        exp_cmd = 1;
                        if (own_i) begin
                            e_rd = 1; e_wr = 0;
                            e_addr = align(bus.i_address);
                            e_wdata = '0;
                        end else begin
                            e_rd = !bus.d_write; e_wr = bus.d_write;
                            e_addr = align(bus.d_address);
                            e_wdata = bus.d_write ? bus.d_wdata : '0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic         ird;
        logic         drd;
        logic         dwr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        int           lat;
        logic         err;
        logic [255:0] rdata;
        logic         e_rd;
        logic         e_wr;
        logic [31:0]  e_addr;
        logic [255:0] e_wdata;
        logic         e_i;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int   k;
        int   n;
        int   pulses;
        logic grants[4];
        logic exp_grants[4];

        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0064, '0, 4, 1'b0, {32{8'hA5}},
                    1'b1, 1'b0, 32'h0000_0060, '0, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h8000_001F, {8{32'h1234_5678}}, 2, 1'b0, {32{8'h3C}},
                    1'b0, 1'b1, 32'h8000_0000, {8{32'h1234_5678}}, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_1234, {8{32'hDEAD_BEEF}}, 1, 1'b1, {16{16'h5AC3}},
                    1'b1, 1'b0, 32'h0000_1220, '0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h4000_0041, {8{32'hCAFE_F00D}}, 0, 1'b0, {8{32'h0F0F_1111}},
                    1'b0, 1'b1, 32'h4000_0040, {8{32'hCAFE_F00D}}, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, '0, 3, 1'b0, {8{32'h7777_0001}},
                    1'b1, 1'b0, 32'hFFFF_FFE0, '0, 1'b1};
        exp_grants[0] = 1'b1; exp_grants[1] = 1'b0; exp_grants[2] = 1'b1; exp_grants[3] = 1'b0;

        bus.i_read = 0; bus.i_address = '0;
        bus.d_read = 0; bus.d_write = 0; bus.d_address = '0; bus.d_wdata = '0;

        // reset
        rst_n = 1'b0;
        #1;
        check("reset_cmd", {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp}, '0);
        check("reset_count", conflict_count, '0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // continuous conflict: alternate grants starting with I
        step();
        mem_lat = 1; mem_err = 0; mem_data = {8{32'h0BAD_F00D}};
        bus.i_read = 1; bus.i_address = 32'h0000_0100;
        bus.d_read = 1; bus.d_address = 32'h0000_0200;
        for (int t = 0; t < 4; t++) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!(bus.i_resp || bus.d_resp) && k < 40);
            check("rr_resp_seen", bus.i_resp || bus.d_resp, 1'b1);
            grants[t] = bus.i_resp;
        end
        step();
        bus.i_read = 0; bus.d_read = 0;
        for (int t = 0; t < 4; t++) check($sformatf("rr_grant%0d", t), grants[t], exp_grants[t]);
        repeat (3) @(negedge clk);
        check("rr_conflict_count", conflict_count, 32'd4);

        // single transactions from the table
        for (int v = 0; v < 5; v++) begin
            step();
            mem_lat = vecs[v].lat; mem_err = vecs[v].err; mem_data = vecs[v].rdata;
            bus.i_read = vecs[v].ird;
            bus.i_address = vecs[v].addr;
            bus.d_read = vecs[v].drd;
            bus.d_write = vecs[v].dwr;
            bus.d_address = vecs[v].addr;
            bus.d_wdata = vecs[v].wdata;
            @(negedge clk);
            check($sformatf("v%0d_no_cmd_yet", v), {bus.pmem_read, bus.pmem_write}, 2'b00);
            @(negedge clk);
            check($sformatf("v%0d_cmd", v), {bus.pmem_read, bus.pmem_write}, {vecs[v].e_rd, vecs[v].e_wr});
            check($sformatf("v%0d_addr", v), bus.pmem_address, vecs[v].e_addr);
            check($sformatf("v%0d_wdata", v), bus.pmem_wdata, vecs[v].e_wdata);
            k = 0;
            while (!(bus.i_resp || bus.d_resp) && k < 20) begin
                @(negedge clk);
                k++;
            end
            check($sformatf("v%0d_resp_cycles", v), k, vecs[v].lat);
            check($sformatf("v%0d_resp_route", v), {bus.i_resp, bus.d_resp}, {vecs[v].e_i, !vecs[v].e_i});
            check($sformatf("v%0d_error", v), {bus.i_error, bus.d_error},
                  {vecs[v].e_i && vecs[v].err, !vecs[v].e_i && vecs[v].err});
            check($sformatf("v%0d_rdata", v), vecs[v].e_i ? bus.i_rdata : bus.d_rdata, vecs[v].rdata);
            step();
            bus.i_read = 0; bus.d_read = 0; bus.d_write = 0;
            @(negedge clk);
            check($sformatf("v%0d_release", v), {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp}, 4'b0000);
            step();
        end

        // spurious completion while idle
        repeat (2) @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        check("spur_no_resp", {bus.i_resp, bus.d_resp, bus.i_error, bus.d_error}, 4'b0000);
        @(negedge clk);
        check("spur_no_cmd", {bus.pmem_read, bus.pmem_write}, 2'b00);

        // I withdraws mid-transaction, D waits; then measure turnaround
        step();
        mem_lat = 3; mem_err = 0; mem_data = {8{32'h1357_9BDF}};
        bus.i_read = 1; bus.i_address = 32'h0000_0300;
        @(negedge clk);
        @(negedge clk);
        check("ab_cmd", {bus.pmem_read, bus.pmem_write}, 2'b10);
        step();
        bus.i_read = 0;
        bus.d_read = 1; bus.d_address = 32'h0000_0400;
        pulses = 0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (bus.i_resp) pulses++;
        end while (!bus.i_resp && k < 20);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus.i_resp) pulses++;
        end while (!(bus.pmem_read || bus.pmem_write) && n < 10);
        check("ab_i_resp_once", pulses, 1);
        check("ab_turnaround", n, 3);
        k = 0;
        while (!bus.d_resp && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("ab_d_resp", bus.d_resp, 1'b1);
        step();
        bus.d_read = 0;

        // randomized traffic against the reference monitor
        mem_rand = 1'b1;
        for (int c = 0; c < 400; c++) begin
            step();
            if (bus.i_read) begin
                if (mon_i_resp) begin
                    if ($urandom_range(0, 1) == 0) bus.i_read = 0;
                    else bus.i_address = $urandom;
                end else if ($urandom_range(0, 39) == 0) begin
                    bus.i_read = 0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                bus.i_read = 1;
                bus.i_address = $urandom;
            end
            if (bus.d_read || bus.d_write) begin
                if (mon_d_resp) begin
                    if ($urandom_range(0, 1) == 0) begin
                        bus.d_read = 0; bus.d_write = 0;
                    end else begin
                        bus.d_address = $urandom;
                        bus.d_wdata = rand256();
                    end
                end else if ($urandom_range(0, 39) == 0) begin
                    bus.d_read = 0; bus.d_write = 0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                n = $urandom_range(1, 3);
                bus.d_read = n[0];
                bus.d_write = n[1];
                bus.d_address = $urandom;
                bus.d_wdata = rand256();
            end
        end
        step();
        bus.i_read = 0; bus.d_read = 0; bus.d_write = 0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((bus.pmem_read || bus.pmem_write) && k < 30);
        check("rand_drain", {bus.pmem_read, bus.pmem_write}, 2'b00);
        mem_rand = 1'b0;
        repeat (3) @(negedge clk);

        // asynchronous reset in the middle of a writeback
        step();
        mem_lat = 20; mem_err = 0;
        bus.d_write = 1; bus.d_address = 32'h0000_0500; bus.d_wdata = rand256();
        @(negedge clk);
        @(negedge clk);
        check("ar_pre_write", bus.pmem_write, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        check("ar_write_drop", {bus.pmem_read, bus.pmem_write}, 2'b00);
        check("ar_count_clear", conflict_count, '0);
        bus.d_write = 0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        step();
        mem_lat = 0; mem_data = {8{32'h2468_ACE0}};
        bus.i_read = 1; bus.i_address = 32'h0000_0613;
        bus.d_read = 1; bus.d_address = 32'h0000_0700;
        @(negedge clk);
        @(negedge clk);
        check("ar_tie_cmd", {bus.pmem_read, bus.pmem_write}, 2'b10);
        check("ar_tie_addr", bus.pmem_address, 32'h0000_0600);
        check("ar_tie_i_resp", {bus.i_resp, bus.d_resp}, 2'b10);
        step();
        bus.i_read = 0; bus.d_read = 0;
        repeat (8) @(negedge clk);
        check("end_idle", {bus.pmem_read, bus.pmem_write}, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_line_arbiter.md
Name: cache_line_arbiter

Overview:
- Shares the single 256-bit physical memory port between the instruction-cache miss path and the data-cache miss/writeback path inside mem_heirarchy.
- Accepts line-fill reads from the I-side, and line reads or writebacks from the D-side.
- Serialises them onto pmem_* with round-robin fairness on conflicts, then routes the response back to the owning cache.
- Maintains a saturating conflict counter for performance analysis.

Parameters:
ADDR_W, 32, physical address width
LINE_W, 256, cache line width in bits
OFFSET_W, 5, line-offset bits forced to zero on pmem_address

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_read  in  1  I-cache line read request, held until i_resp
i_address  in  ADDR_W  I-cache line address
i_resp  out  1  one-cycle completion pulse to I-cache
i_error  out  1  pmem_error forwarded with i_resp
i_rdata  out  LINE_W  line data, valid when i_resp=1
d_read  in  1  D-cache line read request, held until d_resp
d_write  in  1  D-cache line writeback request, held until d_resp
d_address  in  ADDR_W  D-cache line address
d_wdata  in  LINE_W  writeback data
d_resp  out  1  one-cycle completion pulse to D-cache
d_error  out  1  pmem_error forwarded with d_resp
d_rdata  out  LINE_W  line data, valid when d_resp=1
pmem_read  out  1  physical memory read command
pmem_write  out  1  physical memory write command
pmem_address  out  ADDR_W  line-aligned physical address
pmem_wdata  out  LINE_W  physical write data
pmem_resp  in  1  physical memory completion
pmem_error  in  1  physical memory error, valid with pmem_resp
pmem_rdata  in  LINE_W  physical read data
conflict_count  out  32  cycles in IDLE where both sides requested, saturating

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset state while rst_n=0, taking effect immediately:
  - state=IDLE, last_grant=D.
  - All outputs 0: pmem_read, pmem_write, pmem_address, pmem_wdata, i_resp, d_resp, i_error, d_error, conflict_count.
- States: IDLE, BUSY_I, BUSY_D, RELEASE.
- IDLE:
  - i_req = i_read; d_req = d_read | d_write.
  - Only one side requesting: grant it.
  - Both requesting: grant the side that is not last_grant, and increment conflict_count (saturates at 0xFFFF_FFFF).
  - On grant, register:
    - op: write if d_write, else read; d_write wins if d_read and d_write are both 1.
    - address with bits [OFFSET_W-1:0] forced to 0.
    - wdata: d_wdata for a D write, else 0.
  - Next state BUSY_x.
- BUSY_x:
  - pmem_read/pmem_write/pmem_address/pmem_wdata are driven from registers only and stay stable the whole state.
  - The first command cycle is the cycle after the request is sampled (1-cycle grant latency).
  - On pmem_resp=1, in the same cycle (combinational): x_resp=1, x_error=pmem_error, x_rdata=pmem_rdata.
  - At the next edge: pmem_read/pmem_write go to 0, last_grant=x, state=RELEASE.
- RELEASE: exactly one cycle, no grant, so the requester can drop its request. Next state IDLE.
- Response routing:
  - i_rdata and d_rdata may both mirror pmem_rdata at all times.
  - Only the owner's resp/error may be 1. The non-owner's resp/error are 0 always.
- pmem_resp in IDLE or RELEASE: ignored, no resp pulse, no state change.
- Requester drops its request during BUSY: the transaction still completes and the resp pulse is still issued.
- Back-to-back: a side holding its request through RELEASE is re-arbitrated in IDLE. Minimum turnaround from pmem_resp to the next pmem command is 3 edges.
- Reset asserted mid-transaction: pmem_read/pmem_write drop asynchronously and the transaction is abandoned. The memory model must also be reset.

Decomposition:
- Shared package rv32i_types gains:
  - arb_state_t enum {IDLE, BUSY_I, BUSY_D, RELEASE}
  - arb_owner_t enum {OWN_I, OWN_D}
  - constants LINE_W=256, OFFSET_W=5
- One natural sub-module: sat_counter32 (enable, async active-low reset, saturating). It is reusable for the branch_* performance counters.
- FSM, request latch and response routing stay in cache_line_arbiter.

Test Plan:
- Lone I read: i_read=1, i_address=0x0000_0064 -> next cycle pmem_read=1, pmem_address=0x0000_0060. pmem_resp after 4 cycles with rdata=0xA5..A5 -> i_resp=1 for one cycle, i_rdata=0xA5..A5, d_resp=0.
- D writeback: d_write=1, d_address=0x8000_001F, d_wdata=0x1234..; pmem_resp after 2 cycles -> pmem_write=1, pmem_address=0x8000_0000, pmem_wdata matches. d_resp pulses once, pmem_write=0 next cycle.
- Conflict round-robin: both request continuously for 4 transactions -> grants I,D,I,D, conflict_count=4, never both pmem_read and pmem_write high.
- Error path: D read with pmem_error=1 at pmem_resp -> d_error=1 with d_resp, i_error=0. Next transaction's error is 0 when pmem_error=0.
- Spurious and abandoned: pmem_resp=1 in IDLE -> no resp. I request withdrawn mid-BUSY -> i_resp still pulses once. State passes through RELEASE to IDLE.
- Async reset: rst_n=0 mid-BUSY_D without a clock edge -> pmem_write=0 and conflict_count=0 immediately. After release, the first tie grants I.
